tft_busctrl_mod: RTL and testbench

TFT_BUSCTRL_MOD -- requirements
Module: tft_busctrl_mod

---
 rtl/tft_pkg.sv | 43 ++++
 rtl/tft_busctrl_mod_timer.sv | 29 ++
 rtl/tft_busctrl_mod.sv | 194 +++++++++++++++++++
 tb/tb_tft_busctrl_mod.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared types and constants for the 8080-style TFT bus controller.
// States, request bit positions, operation kinds and default phase timing.
package tft_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CMD_L,
    CMD_H,
    DAT_L,
    DAT_H,
    RD_L,
    RD_H,
    DONE,
    CLR
  } state_t;

  typedef enum logic [1:0] {
    OP_WR,
    OP_CMD,
    OP_BURST,
    OP_READ
  } op_t;

  localparam int CALL_RD    = 3;
  localparam int CALL_BURST = 2;
  localparam int CALL_CMD   = 1;
  localparam int CALL_WR    = 0;

  localparam int TCSL_DEF = 3;
  localparam int TCSH_DEF = 25;
  localparam int TMR_W    = 16;

  function automatic logic is_phase(input state_t s);
    return (s == CMD_L) || (s == CMD_H) ||
           (s == DAT_L) || (s == DAT_H) ||
           (s == RD_L)  || (s == RD_H);
  endfunction

  function automatic logic is_low(input state_t s);
    return (s == CMD_L) || (s == DAT_L) || (s == RD_L);
  endfunction

endpackage

// File: rtl/tft_busctrl_mod_timer.sv
// Loadable down-counter; phase_end is high in the last cycle of a phase.
// Loading value N gives a phase lasting exactly N cycles.
module tft_phase_timer
  import tft_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         phase_end
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign phase_end = (cnt == '0);

endmodule

// File: rtl/tft_busctrl_mod.sv
// 8080-style TFT panel bus controller: command, data, burst and read cycles.
// Read path (iCall[3], RD_L/RD_H) is built only when TFT_READ_EN is defined.
module tft_busctrl_mod
  import tft_pkg::*;
#(
  parameter int DW   = 16,
  parameter int TCSL = TCSL_DEF,
  parameter int TCSH = TCSH_DEF,
  parameter int LW   = 16
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [3:0]    iCall,
  input  logic [7:0]    iAddr,
  input  logic [DW-1:0] iData,
  input  logic [LW-1:0] iLen,
  output logic          oDone,
  output logic          oBusy,
  output logic [DW-1:0] oData,
  output logic          TFT_RS,
  output logic          TFT_CS_N,
  output logic          TFT_WR_N,
  output logic          TFT_RD_N,
  output logic [DW-1:0] TFT_DB_O,
  input  logic [DW-1:0] TFT_DB_I,
  output logic          TFT_DB_OE
);

  state_t        state, nxt;
  op_t           op_q, op_n;
  logic          req;
  logic [7:0]    addr_q;
  logic [LW-1:0] rem_q;
  logic [DW-1:0] data_q;
  logic          pend;
  logic          tload;
  logic [TMR_W-1:0] tval;

  logic          rs_q, cs_n_q, wr_n_q;
  logic          done_q, busy_q;
  logic [DW-1:0] db_q;

  // Highest set request bit wins
  always_comb begin
    req  = 1'b0;
    op_n = OP_WR;
    priority case (1'b1)
`ifdef TFT_READ_EN
      iCall[CALL_RD]: begin
        req  = 1'b1;
        op_n = OP_READ;
      end
`endif
      iCall[CALL_BURST]: begin
        req  = 1'b1;
        op_n = OP_BURST;
      end
      iCall[CALL_CMD]: begin
        req  = 1'b1;
        op_n = OP_CMD;
      end
      iCall[CALL_WR]: begin
        req  = 1'b1;
        op_n = OP_WR;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (req) nxt = (op_n == OP_WR) ? DAT_L : CMD_L;
      CMD_L: if (pend) nxt = CMD_H;
      CMD_H: if (pend) begin
        unique case (op_q)
          OP_BURST: nxt = (rem_q == '0) ? DONE : DAT_L;
`ifdef TFT_READ_EN
          OP_READ:  nxt = RD_L;
`endif
          default:  nxt = DONE;
        endcase
      end
      DAT_L: if (pend) nxt = DAT_H;
      DAT_H: if (pend) begin
        if (op_q == OP_BURST && rem_q > LW'(1))
          nxt = DAT_L;
        else
          nxt = DONE;
      end
`ifdef TFT_READ_EN
      RD_L: if (pend) nxt = RD_H;
      RD_H: if (pend) nxt = DONE;
`endif
      DONE: nxt = CLR;
      CLR:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Timer reloads on every entry into a bus phase
  assign tload = (nxt != state) && is_phase(nxt);
  assign tval  = is_low(nxt) ? TMR_W'(TCSL) : TMR_W'(TCSH);

  tft_phase_timer #(
    .W(TMR_W)
  ) u_timer (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .load     (tload),
    .load_val (tval),
    .phase_end(pend)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      op_q   <= OP_WR;
      addr_q <= '0;
      rem_q  <= '0;
      data_q <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req) begin
        op_q   <= op_n;
        addr_q <= iAddr;
        rem_q  <= iLen;
      end
      if (nxt == DAT_L && state != DAT_L)
        data_q <= iData;
      if (state == DAT_H && pend && rem_q != '0)
        rem_q <= rem_q - LW'(1);
    end
  end

  // Pin drivers are registered one cycle behind the state
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rs_q   <= 1'b1;
      cs_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      db_q   <= '0;
    end else begin
      rs_q   <= !(state == CMD_L || state == CMD_H);
      cs_n_q <= !is_phase(state);
      wr_n_q <= !(state == CMD_L || state == DAT_L);
      done_q <= (state == DONE);
      busy_q <= !(state == IDLE || state == CLR);
      if (state == CMD_L || state == CMD_H)
        db_q <= DW'(addr_q);
      else if (state == DAT_L || state == DAT_H)
        db_q <= data_q;
    end
  end

  assign TFT_RS   = rs_q;
  assign TFT_CS_N = cs_n_q;
  assign TFT_WR_N = wr_n_q;
  assign TFT_DB_O = db_q;
  assign oDone    = done_q;
  assign oBusy    = busy_q;

`ifdef TFT_READ_EN
  logic          rd_n_q, oe_q;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rd_n_q  <= 1'b1;
      oe_q    <= 1'b1;
      rdata_q <= '0;
    end else begin
      rd_n_q <= !(state == RD_L);
      oe_q   <= !(state == RD_L || state == RD_H);
      if (state == RD_L && pend)
        rdata_q <= TFT_DB_I;
    end
  end

  assign TFT_RD_N  = rd_n_q;
  assign TFT_DB_OE = oe_q;
  assign oData     = rdata_q;
`else
  logic unused_rd;
  assign unused_rd = ^{iCall[CALL_RD], TFT_DB_I};

  assign TFT_RD_N  = 1'b1;
  assign TFT_DB_OE = 1'b1;
  assign oData     = '0;
`endif

endmodule

// File: tb/tb_tft_busctrl_mod.sv
// Self-checking bench for tft_busctrl_mod: vector table, random ops, corners.
// Follows TFT_READ_EN the same way the design does.
module tb_tft_busctrl_mod;

  localparam int TCSL = 3;
  localparam int TCSH = 25;
  localparam int PH   = TCSL + TCSH;
`ifdef TFT_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  iCall = '0;
  logic [7:0]  iAddr = '0;
  logic [15:0] iData = '0;
  logic [15:0] iLen  = '0;
  logic        oDone, oBusy;
  logic [15:0] oData;
  logic        TFT_RS, TFT_CS_N, TFT_WR_N, TFT_RD_N, TFT_DB_OE;
  logic [15:0] TFT_DB_O;
  logic [15:0] TFT_DB_I = '0;

  tft_busctrl_mod #(
    .DW(16), .TCSL(TCSL), .TCSH(TCSH), .LW(16)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .iCall    (iCall),
    .iAddr    (iAddr),
    .iData    (iData),
    .iLen     (iLen),
    .oDone    (oDone),
    .oBusy    (oBusy),
    .oData    (oData),
    .TFT_RS   (TFT_RS),
    .TFT_CS_N (TFT_CS_N),
    .TFT_WR_N (TFT_WR_N),
    .TFT_RD_N (TFT_RD_N),
    .TFT_DB_O (TFT_DB_O),
    .TFT_DB_I (TFT_DB_I),
    .TFT_DB_OE(TFT_DB_OE)
  );

  always #5 CLOCK = ~CLOCK;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: the list of bus phases an operation must produce
  logic [16:0] exp_wr[$];
  bit          exp_rd;
  bit          exp_burst;
  int          exp_n;
  logic [15:0] exp_odata = '0;

  task automatic model(input logic [3:0] call, input logic [7:0] addr,
                       input logic [15:0] data, input logic [15:0] len);
    exp_wr.delete();
    exp_rd    = 1'b0;
    exp_burst = 1'b0;
    if (RD_EN && call[3]) begin
      exp_wr.push_back({1'b0, 8'h00, addr});
      exp_rd = 1'b1;
    end else if (call[2]) begin
      exp_burst = 1'b1;
      exp_wr.push_back({1'b0, 8'h00, addr});
      for (int i = 0; i < int'(len); i++) exp_wr.push_back({1'b1, data});
    end else if (call[1]) begin
      exp_wr.push_back({1'b0, 8'h00, addr});
    end else if (call[0]) begin
      exp_wr.push_back({1'b1, data});
    end
    exp_n = exp_wr.size() + (exp_rd ? 1 : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rs"},   TFT_RS, 1);
    chk({tag, " cs_n"}, TFT_CS_N, 1);
    chk({tag, " wr_n"}, TFT_WR_N, 1);
    chk({tag, " rd_n"}, TFT_RD_N, 1);
    chk({tag, " db_o"}, TFT_DB_O, 0);
    chk({tag, " oe"},   TFT_DB_OE, 1);
    chk({tag, " done"}, oDone, 0);
    chk({tag, " busy"}, oBusy, 0);
    chk({tag, " odata"}, oData, 0);
  endtask

  task automatic run_op(input string nm, input logic [3:0] call,
                        input logic [7:0] addr, input logic [15:0] data,
                        input logic [15:0] len, input logic [15:0] dbi,
                        input int hold, input bit use_tab,
                        input int tab_lat, input int tab_nwr);
    int lat, dones, cslow, wrlow, oelow, rdlow, idx, budget;
    logic busy1, prev_wr;
    logic [15:0] od;
    model(call, addr, data, len);
    lat = -1; dones = 0; cslow = 0; wrlow = 0;
    oelow = 0; rdlow = 0; idx = 0; busy1 = 1'b0;
    prev_wr = 1'b1; od = '0;
    budget = (exp_n == 0) ? 10 : 1 + exp_n * PH + 4;
    @(negedge CLOCK);
    iCall = call; iAddr = addr; iData = data;
    iLen = len; TFT_DB_I = dbi;
    @(posedge CLOCK);
    for (int k = 0; k < budget; k++) begin
      @(negedge CLOCK);
      if (k == hold) iCall = '0;
      if (k == 0) begin
        iAddr = ~addr;
        iLen  = len + 16'd7;
        if (!exp_burst) iData = ~data;
      end
      if (!TFT_CS_N) cslow++;
      if (!TFT_WR_N) begin
        wrlow++;
        if (prev_wr) begin
          if (idx < exp_wr.size())
            chk({nm, " wr phase"}, {TFT_RS, TFT_DB_O}, exp_wr[idx]);
          idx++;
        end
      end
      prev_wr = TFT_WR_N;
      if (!TFT_DB_OE) oelow++;
      if (!TFT_RD_N) rdlow++;
      if (k == 1) busy1 = oBusy;
      if (oDone) begin
        dones++;
        if (lat < 0) begin
          lat = k;
          od  = oData;
        end
      end
    end
    if (exp_rd) exp_odata = dbi;
    chk({nm, " done count"}, dones, (exp_n > 0) ? 1 : 0);
    chk({nm, " latency"}, lat, (exp_n > 0) ? 1 + exp_n * PH : -1);
    if (use_tab) begin
      chk({nm, " tab latency"}, lat, tab_lat);
      chk({nm, " tab phases"}, idx, tab_nwr);
    end
    chk({nm, " wr phases"}, idx, exp_wr.size());
    chk({nm, " cs low"}, cslow, exp_n * PH);
    chk({nm, " wr low"}, wrlow, exp_wr.size() * TCSL);
    chk({nm, " oe low"}, oelow, exp_rd ? PH : 0);
    chk({nm, " rd low"}, rdlow, exp_rd ? TCSL : 0);
    chk({nm, " busy early"}, busy1, (exp_n > 0) ? 1 : 0);
    chk({nm, " busy end"}, oBusy, 0);
    chk({nm, " odata"}, (exp_n > 0) ? od : oData, exp_odata);
  endtask

  typedef struct {
    logic [3:0]  call;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] len;
    logic [15:0] dbi;
    int          hold;
    int          lat;
    int          nwr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt;
    vecs[0] = '{4'b0010, 8'h22, 16'h0000, 16'd0, 16'h0000, 0, 29, 1};
    vecs[1] = '{4'b0100, 8'h2C, 16'hF800, 16'd3, 16'h0000, 0, 113, 4};
    vecs[2] = '{4'b0100, 8'h2C, 16'hF800, 16'd0, 16'h0000, 0, 29, 1};
    vecs[3] = '{4'b0001, 8'h00, 16'h1234, 16'd0, 16'h0000, 0, 29, 1};
    vecs[4] = '{4'b0111, 8'h2A, 16'h07E0, 16'd2, 16'h0000, 40, 85, 3};
`ifdef TFT_READ_EN
    vecs[5] = '{4'b1000, 8'h04, 16'h0000, 16'd0, 16'h9341, 0, 57, 1};
    vecs[6] = '{4'b1100, 8'h10, 16'hBEEF, 16'd1, 16'h5A5A, 0, 57, 1};
`else
    vecs[5] = '{4'b1000, 8'h04, 16'h0000, 16'd0, 16'h9341, 0, -1, 0};
    vecs[6] = '{4'b1100, 8'h10, 16'hBEEF, 16'd1, 16'h5A5A, 0, 57, 2};
`endif
    vecs[7] = '{4'b0000, 8'h55, 16'h1111, 16'd2, 16'h0000, 0, -1, 0};

    repeat (3) @(negedge CLOCK);
    check_reset_outputs("reset");
    RESET = 1'b0;
    repeat (2) @(negedge CLOCK);

    for (int v = 0; v < 8; v++)
      run_op($sformatf("vec%0d", v), vecs[v].call, vecs[v].addr,
             vecs[v].data, vecs[v].len, vecs[v].dbi, vecs[v].hold,
             1'b1, vecs[v].lat, vecs[v].nwr);

    // Reset asserted while the single write sits in DAT_L
    @(negedge CLOCK);
    iCall = 4'b0001; iData = 16'hA5A5;
    @(posedge CLOCK);
    @(negedge CLOCK);
    iCall = '0;
    @(negedge CLOCK);
    chk("pre-reset cs", TFT_CS_N, 0);
    chk("pre-reset wr", TFT_WR_N, 0);
    #1 RESET = 1'b1;
    #1 check_reset_outputs("midreset");
    exp_odata = '0;
    @(negedge CLOCK);
    RESET = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLOCK);
      if (oDone || !TFT_CS_N) cnt++;
    end
    chk("post-reset quiet", cnt, 0);
    run_op("after reset", 4'b0010, 8'h29, 16'h0, 16'd0, 16'h0,
           0, 1'b1, 29, 1);

    for (int r = 0; r < 24; r++)
      run_op($sformatf("rand%0d", r), 4'($urandom_range(0, 15)),
             8'($urandom), 16'($urandom), 16'($urandom_range(0, 4)),
             16'($urandom), $urandom_range(0, 20), 1'b0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
